// File: rtl/lcd1602_text_ctrl.sv
// lcd1602_text_ctrl: write-only HD44780 / LCD1602 text controller.
// After reset it waits for the power-up time and sends the 5-command init sequence.
// After init it draws two text rows, either on request or continuously.
// Optional feature: define LCD_AUTO_REFRESH_EN to redraw frames back-to-back forever.
// Handshake: ready=1 only in IDLE. A one-cycle update pulse there starts a frame.
// An update at any other time is merged into one pending request.
// A pending request is served when the current INIT or frame ends.
// dbg_state exposes the FSM state (0 PWRUP, 1 INIT, 2 IDLE, 3 FRAME).
module lcd1602_text_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int STEP_HZ    = 500,
    parameter int POWERUP_MS = 20,
    parameter int COLS       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8*COLS-1:0] row0_text,
    input  logic [8*COLS-1:0] row1_text,
    input  logic              update,
    output logic              ready,
    output logic              done,
    output logic              lcd_en,
    output logic              lcd_rw,
    output logic              lcd_rs,
    output logic [7:0]        lcd_data,
    output logic [1:0]        dbg_state
);

    localparam int STEP_CYC = CLK_HZ / STEP_HZ;
    localparam int PWR_CYC  = (CLK_HZ / 1000) * POWERUP_MS;
    localparam int CNT_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int PWR_W    = (PWR_CYC > 1) ? $clog2(PWR_CYC) : 1;
    localparam int IDX_W    = 7;

    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_HALF  = CNT_W'(STEP_CYC / 2);
    localparam logic [PWR_W-1:0] PWR_LAST   = PWR_W'(PWR_CYC - 1);
    localparam logic [IDX_W-1:0] INIT_LAST  = IDX_W'(4);
    localparam logic [IDX_W-1:0] COLS_IDX   = IDX_W'(COLS);
    localparam logic [IDX_W-1:0] ADDR1_IDX  = IDX_W'(COLS + 1);
    localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(2 * COLS + 1);

    localparam logic [1:0] S_PWRUP = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;
    localparam logic [1:0] S_FRAME = 2'd3;

`ifdef LCD_AUTO_REFRESH_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic [1:0]        state;
    logic [PWR_W-1:0]  pwr_cnt;
    logic [CNT_W-1:0]  step_cnt;
    logic [IDX_W-1:0]  step_idx;
    logic              pending;
    logic [8*COLS-1:0] snap0;
    logic [8*COLS-1:0] snap1;

    logic              req;
    logic              busy;
    logic              step_end;
    logic              seq_end;
    logic              start_frame;
    logic [IDX_W-1:0]  next_idx;
    logic              next_rs;
    logic [7:0]        next_data;

    function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] i);
        case (i)
            IDX_W'(0): return 8'h38;
            IDX_W'(1): return 8'h08;
            IDX_W'(2): return 8'h01;
            IDX_W'(3): return 8'h06;
            default:   return 8'h0C;
        endcase
    endfunction

    // Character k of a row; character 0 sits in the top byte.
    function automatic logic [7:0] row_char(input logic [8*COLS-1:0] row, input logic [IDX_W-1:0] k);
        logic [8*COLS-1:0] sh;
        sh = row << {k, 3'b000};
        return sh[8*COLS-1 -: 8];
    endfunction

    // Frame step layout: ADDR0, row 0 chars, ADDR1, row 1 chars. Returns {rs, data}.
    function automatic logic [8:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [8*COLS-1:0] r0,
                                              input logic [8*COLS-1:0] r1);
        if (idx == '0)
            return {1'b0, 8'h80};
        else if (idx == ADDR1_IDX)
            return {1'b0, 8'hC0};
        else if (idx <= COLS_IDX)
            return {1'b1, row_char(r0, idx - IDX_W'(1))};
        else
            return {1'b1, row_char(r1, idx - ADDR1_IDX - IDX_W'(1))};
    endfunction

    // Step sequencing decisions and the byte for the step that follows
    always_comb begin
        req         = update & ~AUTO;
        busy        = (state == S_INIT) || (state == S_FRAME);
        step_end    = busy && (step_cnt == STEP_LAST);
        seq_end     = step_end &&
                      (((state == S_INIT)  && (step_idx == INIT_LAST)) ||
                       ((state == S_FRAME) && (step_idx == FRAME_LAST)));
        // A request that arrives in the final cycle of a sequence is served by chaining.
        // Entering IDLE would otherwise leave a pending flag nobody consumes.
        start_frame = ((state == S_IDLE) && req) || (seq_end && (pending || req || AUTO));
        next_idx    = step_idx + IDX_W'(1);
        if (state == S_INIT)
            {next_rs, next_data} = {1'b0, init_cmd(next_idx)};
        else
            {next_rs, next_data} = frame_byte(next_idx, snap0, snap1);
    end

    // Main FSM, step timing, snapshot and pending-request bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_PWRUP;
            pwr_cnt  <= '0;
            step_cnt <= '0;
            step_idx <= '0;
            pending  <= 1'b0;
            snap0    <= '0;
            snap1    <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (start_frame) begin
            // Snapshot is taken now, so a request seen in this cycle is already satisfied.
            state    <= S_FRAME;
            step_cnt <= '0;
            step_idx <= '0;
            pending  <= 1'b0;
            snap0    <= row0_text;
            snap1    <= row1_text;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h80;
        end else begin
            if (req)
                pending <= 1'b1;
            case (state)
                S_PWRUP: begin
                    if (pwr_cnt == PWR_LAST) begin
                        state    <= S_INIT;
                        step_cnt <= '0;
                        step_idx <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_cmd(IDX_W'(0));
                    end else begin
                        pwr_cnt <= pwr_cnt + PWR_W'(1);
                    end
                end
                S_INIT, S_FRAME: begin
                    if (seq_end) begin
                        state    <= S_IDLE;
                        step_cnt <= '0;
                        step_idx <= '0;
                    end else if (step_end) begin
                        step_cnt <= '0;
                        step_idx <= next_idx;
                        lcd_rs   <= next_rs;
                        lcd_data <= next_data;
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                    end
                end
                default: step_cnt <= '0;
            endcase
        end
    end

    // Outputs decoded from registered state; en falls once mid-step
    always_comb begin
        ready     = (state == S_IDLE);
        done      = (state == S_FRAME) && (step_idx == FRAME_LAST) && step_end;
        lcd_en    = busy && (step_cnt < STEP_HALF);
        lcd_rw    = 1'b0;
        dbg_state = state;
    end

endmodule

// File: doc/lcd1602_text_ctrl.md
# lcd1602_text_ctrl

Parametrised HD44780/LCD1602 write-only controller. Performs the power-up wait and the 5-command init sequence, then writes two text rows supplied on input ports. Rows are redrawn on request with a ready/busy handshake, or continuously when auto-refresh is compiled in. Sits between the fish-tank status/formatting logic and the LCD pins.

## Interface
Parameters:
- CLK_HZ, 50_000_000: system clock frequency.
- STEP_HZ, 500: LCD write rate; one byte per step; must be ≤ 500.
- POWERUP_MS, 20: wait after reset before the first command.
- COLS, 16: characters per row, 1..40.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- row0_text  in  8*COLS  line 1 ASCII; char 0 = bits [8*COLS-1 -: 8].
- row1_text  in  8*COLS  line 2 ASCII, same ordering.
- update  in  1  redraw request, sampled every cycle.
- ready  out  1  init complete and no frame in progress.
- done  out  1  one-cycle pulse when a frame's last byte step ends.
- lcd_en  out  1  LCD enable; data latched on its falling edge.
- lcd_rw  out  1  constant 0 (write only).
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_data  out  8  LCD bus.

## Operation
- Derived constants: STEP_CYC = CLK_HZ/STEP_HZ; PWR_CYC = (CLK_HZ/1000)*POWERUP_MS.
- Reset values:
  - ready=0, done=0, lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_data=8'h00.
  - FSM in PWRUP; step counter 0; pending flag 0.
- States:
  - PWRUP: count PWR_CYC cycles, then go to INIT.
  - INIT: 5 command steps: 0x38, 0x08, 0x01, 0x06, 0x0C. Then IDLE.
  - IDLE: ready=1, step counter held at 0, lcd_en=0.
  - FRAME: ADDR0 (0x80), COLS data steps, ADDR1 (0xC0), COLS data steps. Length is 2*COLS+2 steps; then back to IDLE.
- Update handshake:
  - In IDLE, update=1 snapshots both row inputs into internal registers, enters FRAME, and drops ready the next cycle.
  - Frame bytes come only from the snapshot. Input changes during a frame do not take effect until the next frame.
  - update during PWRUP, INIT or FRAME sets a single pending flag; further requests merge into it.
  - If pending is set when a frame or INIT ends, the FSM clears the flag, re-snapshots, and starts a new frame without entering IDLE. ready stays 0 throughout.
- done:
  - Pulses in the cycle the last row-1 step ends.
  - Also pulses when that frame is immediately chained into another.
- lcd_rs is 0 for init and address steps, 1 for character steps.
- rst mid-operation: all state returns to reset values in the next cycle, including a full PWRUP wait. The pending flag and snapshot are discarded.

## Timing
- Step counter runs 0..STEP_CYC-1 while in INIT or FRAME.
- lcd_rs and lcd_data update in the cycle the step starts (counter = 0) and are held for the whole step.
- lcd_en = 1 while counter < STEP_CYC/2, else 0. This puts one falling edge mid-step, with half a step of setup and hold.
- First INIT step starts the cycle after the PWRUP count expires.
- Frame latency: update is sampled in IDLE; the ADDR0 step starts on the next cycle.
- Frame duration: (2*COLS+2)*STEP_CYC cycles. With defaults: 34 × 100_000 cycles.
- After a step ends, lcd_data and lcd_rs hold their last value; lcd_en=0 in IDLE.

## Configuration
- Macro LCD_AUTO_REFRESH_EN.
- Defined:
  - On finishing a frame, the FSM always starts a new frame with a fresh snapshot instead of entering IDLE.
  - ready stays 0 after init, and update is ignored.
  - done still pulses once per frame.
- Undefined: on-demand behaviour exactly as described in Operation.

## Test plan
Bench parameters: CLK_HZ=1000, STEP_HZ=100, POWERUP_MS=2, COLS=4, giving STEP_CYC=10 and PWR_CYC=2.

- Init: release rst → lcd_en=0 for 2 cycles. Then 5 steps of 10 cycles each with rs=0 and data 0x38, 0x08, 0x01, 0x06, 0x0C. Each step has exactly one en fall, at counter 5. Then ready=1.
- Frame: row0="ABCD", row1="wxyz", one-cycle update in IDLE → bytes 0x80, 41, 42, 43, 44, 0xC0, 77, 78, 79, 7A over 100 cycles. rs pattern is 0,1,1,1,1,0,1,1,1,1. done pulses once; ready returns to 1.
- Snapshot: change row0 to "QQQQ" during the ADDR0 step → the frame still shows "ABCD".
- Pending: update pulses three times during a frame → exactly one chained frame (done pulses twice, no IDLE in between). Then ready=1.
- Reset mid-frame: assert rst in the third char step → next cycle all outputs are at reset values. The full PWRUP and INIT sequence is repeated, and no chained frame follows.
- With LCD_AUTO_REFRESH_EN: after init, frames repeat back-to-back with a done pulse every 100 cycles, and ready stays 0.
